// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - two-paddle position controller with per-paddle IDLE/SLOW/FAST acceleration
module paddle_ctrl #(
  parameter int SCREEN_H    = 480,
  parameter int PADDLE_H    = 80,
  parameter int STEP        = 4,
  parameter int FAST_STEP   = 8,
  parameter int HOLD_FRAMES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  input  logic       frame_tick,
  input  logic       recenter,
  output logic [9:0] left_y,
  output logic [9:0] right_y,
  output logic       left_moving,
  output logic       right_moving
);

  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_e;

  localparam int CW = $clog2(HOLD_FRAMES + 1);
  localparam logic [9:0] LIMIT  = 10'(SCREEN_H - PADDLE_H);
  localparam logic [9:0] CENTER = 10'((SCREEN_H - PADDLE_H) / 2);

  typedef struct packed {
    state_e        st;
    logic          dn;
    logic [CW-1:0] cnt;
    logic [9:0]    y;
  } pad_t;

  localparam pad_t PAD_HOME = '{st: IDLE, dn: 1'b0, cnt: '0, y: CENTER};

  logic [3:0] key_q;
  pad_t       left_q, left_d, right_q, right_d;

  // Down moves use an 11-bit sum so y+s never wraps before the clamp.
  function automatic logic [9:0] move(input logic [9:0] y, input logic dn, input logic [9:0] s);
    logic [10:0] sum;
    sum = {1'b0, y} + {1'b0, s};
    if (dn)
      return (sum <= {1'b0, LIMIT}) ? sum[9:0] : LIMIT;
    else
      return (y >= s) ? (y - s) : 10'd0;
  endfunction

  function automatic pad_t step_pad(input pad_t p, input logic up, input logic down);
    pad_t n;
    n = p;
    if (up == down) begin
      n.st  = IDLE;
      n.cnt = '0;
    end else if (p.st == IDLE || down != p.dn) begin
      n.st  = SLOW;
      n.cnt = CW'(1);
      n.dn  = down;
      n.y   = move(p.y, down, 10'(STEP));
    end else if (p.st == SLOW) begin
      if (p.cnt == CW'(HOLD_FRAMES)) begin
        n.st = FAST;
        n.y  = move(p.y, p.dn, 10'(FAST_STEP));
      end else begin
        n.cnt = p.cnt + CW'(1);
        n.y   = move(p.y, p.dn, 10'(STEP));
      end
    end else begin
      n.y = move(p.y, p.dn, 10'(FAST_STEP));
    end
    return n;
  endfunction

  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    if (recenter) begin
      left_d  = PAD_HOME;
      right_d = PAD_HOME;
    end else if (frame_tick) begin
      left_d  = step_pad(left_q,  key_q[2], key_q[3]);
      right_d = step_pad(right_q, key_q[0], key_q[1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q   <= 4'd0;
      left_q  <= PAD_HOME;
      right_q <= PAD_HOME;
    end else begin
      key_q   <= key_in;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign left_y       = left_q.y;
  assign right_y      = right_q.y;
  assign left_moving  = (left_q.st != IDLE);
  assign right_moving = (right_q.st != IDLE);

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter SCREEN_H, default 480: visible screen height in pixels; SHALL satisfy PADDLE_H < SCREEN_H <= 1023.
REQ-002 Parameter PADDLE_H, default 80: paddle height in pixels.
REQ-003 Parameter STEP, default 4: pixels moved per frame tick in SLOW state.
REQ-004 Parameter FAST_STEP, default 8: pixels moved per frame tick in FAST state; SHALL satisfy STEP <= FAST_STEP <= SCREEN_H-PADDLE_H.
REQ-005 Parameter HOLD_FRAMES, default 16: number of SLOW ticks before acceleration; SHALL be >= 1.
REQ-006 clk  input  1  system clock (CLK100MHZ domain); one clock, all logic on its rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 key_in  input  4  key levels from the keyboard decoder: [0] right up, [1] right down, [2] left up, [3] left down.
REQ-009 frame_tick  input  1  one-cycle pulse per video frame.
REQ-010 recenter  input  1  one-cycle pulse from score logic; returns both paddles to centre.
REQ-011 left_y  output  10  left paddle top-edge row.
REQ-012 right_y  output  10  right paddle top-edge row.
REQ-013 left_moving  output  1  high when the left paddle FSM is not IDLE.
REQ-014 right_moving  output  1  high when the right paddle FSM is not IDLE.

Function
REQ-015 key_in SHALL be registered into key_q every cycle; all tick decisions SHALL use key_q, giving 1 cycle of input latency.
REQ-016 Each paddle SHALL have an independent, identical FSM with states IDLE, SLOW, FAST, a direction register (UP/DOWN) and a hold counter cnt.
REQ-017 Per paddle, dir = UP if only the up bit is set, DOWN if only the down bit is set, otherwise NONE (both set counts as NONE).
REQ-018 State, cnt, direction and position SHALL change only on frame_tick or recenter cycles.
REQ-019 On a tick with dir NONE: state becomes IDLE, cnt becomes 0, and there is no movement.
REQ-020 On a tick where state is IDLE, or dir differs from the stored direction: state becomes SLOW, cnt becomes 1, the direction is stored, and the paddle moves STEP.
REQ-021 On a tick in SLOW with the same dir: if cnt == HOLD_FRAMES, state becomes FAST and the paddle moves FAST_STEP; otherwise cnt increments and the paddle moves STEP.
REQ-022 On a tick in FAST with the same dir: the paddle moves FAST_STEP; cnt is held.
REQ-023 Moving UP SHALL compute y' = (y >= s) ? y-s : 0, where s is the step size.
REQ-024 Moving DOWN SHALL compute y' = (y+s <= SCREEN_H-PADDLE_H) ? y+s : SCREEN_H-PADDLE_H, using at least 11-bit arithmetic with no wrap.
REQ-025 Reaching a limit SHALL NOT change the FSM state; a held key keeps the paddle at the limit with *_moving=1.
REQ-026 recenter SHALL set both y to CENTER=(SCREEN_H-PADDLE_H)/2, both states to IDLE, and both cnt to 0.
REQ-027 recenter SHALL have priority over a coincident frame_tick.
REQ-028 Outputs SHALL be registered and reflect a tick's update on the cycle after the tick.

Reset
REQ-029 While rst_n is low at a clk edge, left_y and right_y SHALL be CENTER (200 with defaults), states IDLE, cnt 0, key_q 0, and left_moving and right_moving 0.
REQ-030 Reset SHALL take priority over recenter and frame_tick; a reset mid-movement SHALL abandon the movement, and the first tick after release behaves as from IDLE.

Verification
REQ-031 Reset: rst_n low for 2 cycles, then high -> left_y=right_y=200, *_moving=0; ticks with key_in=0 leave all values unchanged.
REQ-032 Acceleration: key_in=4'b0100 held for 20 ticks -> left_y=136 after tick 16, then 128/120/112/104 after ticks 17-20; right_y=200 throughout.
REQ-033 Clamp bottom: key_in=4'b0010 from 200 -> right_y=264 after tick 16 and 400 after tick 33; stays 400 with right_moving=1 on ticks 34-40.
REQ-034 Conflict and clamp top: key_in=4'b0011 -> right_y unchanged, right_moving=0; left paddle at y=2 with up held, next tick -> left_y=0.
REQ-035 Reversal: in FAST moving up, switch to down -> next tick moves +4 and the state is SLOW with cnt=1.
REQ-036 Recenter: recenter and frame_tick in the same cycle while keys are held -> y=200 and IDLE; the next tick moves exactly STEP (4).
